register_file_banked: RTL

Parametrised successor to the 4x8 core register file: a WIDTH-bit, 2^ADDR_W-entry, two-read/one-write register file with BANKS selectable register banks (context swap) and a sequenced clear of the active bank. Sits between decode (addresses) and ALU/writeback in the TinyChip datapath. Reads are registered, with write-first bypass. All state is on one clock with synchronous reset.

---
 rtl/rf_pkg.sv | 18 +
 rtl/rf_clear_seq.sv | 73 +++++++
 rtl/register_file_banked.sv | 134 +++++++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// Shared types and helpers for the banked register file.
package rf_pkg;

    typedef enum logic [0:0] {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_t;

    // Bank index width, clamped so a single-bank build still has a 1-bit port.
    function automatic int bank_w(input int banks);
        if (banks <= 2) begin
            return 1;
        end else begin
            return $clog2(banks);
        end
    endfunction

endpackage

// File: rtl/rf_clear_seq.sv
// Clear sequencer: walks a pointer over every entry of the active bank,
// raising busy for exactly one cycle per entry.
module rf_clear_seq
    import rf_pkg::*;
#(
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_req,
    output logic              busy,
    output logic              clr_en,
    output logic [ADDR_W-1:0] clr_addr
);

    rf_state_t         state_r;
    rf_state_t         state_s;
    logic [ADDR_W-1:0] ptr_r;
    logic [ADDR_W-1:0] ptr_s;
    logic              busy_r;
    logic              busy_s;

    // State, pointer and busy registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= RF_IDLE;
            ptr_r   <= {ADDR_W{1'b0}};
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            ptr_r   <= ptr_s;
            busy_r  <= busy_s;
        end
    end

    // Next-state logic; a request arriving while clearing is simply dropped.
    always_comb begin
        state_s = state_r;
        ptr_s   = ptr_r;
        busy_s  = busy_r;
        case (state_r)
            RF_IDLE: begin
                if (clear_req) begin
                    state_s = RF_CLEAR;
                    ptr_s   = {ADDR_W{1'b0}};
                    busy_s  = 1'b1;
                end else begin
                    busy_s  = 1'b0;
                end
            end
            RF_CLEAR: begin
                if (ptr_r == {ADDR_W{1'b1}}) begin
                    state_s = RF_IDLE;
                    ptr_s   = {ADDR_W{1'b0}};
                    busy_s  = 1'b0;
                end else begin
                    ptr_s   = ptr_r + ADDR_W'(1'b1);
                    busy_s  = 1'b1;
                end
            end
            default: begin
                state_s = RF_IDLE;
                ptr_s   = {ADDR_W{1'b0}};
                busy_s  = 1'b0;
            end
        endcase
    end

    assign busy     = busy_r;
    assign clr_en   = busy_r;
    assign clr_addr = ptr_r;

endmodule

// File: rtl/register_file_banked.sv
// Banked 2R/1W register file with registered, write-first reads,
// a wrapping active-bank counter and a sequenced clear of the active bank.
module register_file_banked
    import rf_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 2,
    parameter int BANKS  = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [ADDR_W-1:0]         rd_addr1,
    input  logic [ADDR_W-1:0]         rd_addr2,
    input  logic [ADDR_W-1:0]         wr_addr,
    input  logic                      wr_en,
    input  logic [WIDTH-1:0]          wr_data,
    input  logic                      bank_swap,
    input  logic                      clear_req,
    output logic [WIDTH-1:0]          rd_data1,
    output logic [WIDTH-1:0]          rd_data2,
    output logic [bank_w(BANKS)-1:0]  active_bank,
    output logic                      busy
);

    localparam int DEPTH  = 1 << ADDR_W;
    localparam int BANK_W = bank_w(BANKS);

    logic [WIDTH-1:0]  cell_s [BANKS][DEPTH];
    logic [BANK_W-1:0] active_bank_r;
    logic [BANK_W-1:0] bank_next_s;
    logic [WIDTH-1:0]  rd_data1_r;
    logic [WIDTH-1:0]  rd_data2_r;
    logic [WIDTH-1:0]  rd_next1_s;
    logic [WIDTH-1:0]  rd_next2_s;
    logic              busy_s;
    logic              clr_en_s;
    logic [ADDR_W-1:0] clr_addr_s;
    logic              wr_acc_s;
    logic              wr_any_s;
    logic [ADDR_W-1:0] wr_sel_addr_s;
    logic [WIDTH-1:0]  wr_sel_data_s;

    rf_clear_seq #(
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk       (clk),
        .reset     (reset),
        .clear_req (clear_req),
        .busy      (busy_s),
        .clr_en    (clr_en_s),
        .clr_addr  (clr_addr_s)
    );

    // Write-port arbitration: the clear sequencer owns the port while busy.
    always_comb begin
        wr_acc_s = wr_en & ~busy_s;
        if (clr_en_s) begin
            wr_any_s      = 1'b1;
            wr_sel_addr_s = clr_addr_s;
            wr_sel_data_s = {WIDTH{1'b0}};
        end else begin
            wr_any_s      = wr_acc_s;
            wr_sel_addr_s = wr_addr;
            wr_sel_data_s = wr_data;
        end
    end

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        for (genvar a = 0; a < DEPTH; a++) begin : g_entry
            logic [WIDTH-1:0] cell_r;

            // One storage entry; only the active bank ever sees a write.
            always_ff @(posedge clk) begin
                if (reset) begin
                    cell_r <= {WIDTH{1'b0}};
                end else if (wr_any_s && (active_bank_r == BANK_W'(b))
                             && (wr_sel_addr_s == ADDR_W'(a))) begin
                    cell_r <= wr_sel_data_s;
                end
            end

            assign cell_s[b][a] = cell_r;
        end
    end

    // Read muxes with write-first bypass of an accepted write.
    always_comb begin
        if (wr_acc_s && (wr_addr == rd_addr1)) begin
            rd_next1_s = wr_data;
        end else begin
            rd_next1_s = cell_s[active_bank_r][rd_addr1];
        end
        if (wr_acc_s && (wr_addr == rd_addr2)) begin
            rd_next2_s = wr_data;
        end else begin
            rd_next2_s = cell_s[active_bank_r][rd_addr2];
        end
    end

    // Registered read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data1_r <= {WIDTH{1'b0}};
            rd_data2_r <= {WIDTH{1'b0}};
        end else begin
            rd_data1_r <= rd_next1_s;
            rd_data2_r <= rd_next2_s;
        end
    end

    // Wrapping successor of the active bank.
    always_comb begin
        if (active_bank_r == BANK_W'(BANKS - 1)) begin
            bank_next_s = {BANK_W{1'b0}};
        end else begin
            bank_next_s = active_bank_r + BANK_W'(1'b1);
        end
    end

    // Active bank counter; swaps are ignored while a clear is running.
    always_ff @(posedge clk) begin
        if (reset) begin
            active_bank_r <= {BANK_W{1'b0}};
        end else if (bank_swap && !busy_s) begin
            active_bank_r <= bank_next_s;
        end
    end

    assign rd_data1    = rd_data1_r;
    assign rd_data2    = rd_data2_r;
    assign active_bank = active_bank_r;
    assign busy        = busy_s;

endmodule
